bip_datapath: RTL

- Execution datapath of the BIP core, directly downstream of the control unit. It consumes SEL_A, SEL_B, WR_ACC, OP, WR_RAM, RD_RAM and the 11-bit OPERAND.
- Contains the accumulator, the operand sign extender, the add/sub unit and the data RAM.
- Adds a handshaked memory-dump engine so the debug/UART layer can stream data RAM contents out after the program halts.

---
 rtl/bip_pkg.sv | 19 +
 rtl/bip_data_ram.sv | 29 ++
 rtl/bip_datapath.sv | 161 ++++++++++++++++
 3 files changed

// File: rtl/bip_pkg.sv
// Shared encodings for the BIP execution datapath: accumulator source select,
// ALU operation and memory-dump FSM states.
package bip_pkg;

  localparam logic [1:0] SELA_RAM  = 2'b00;
  localparam logic [1:0] SELA_IMM  = 2'b01;
  localparam logic [1:0] SELA_ALU  = 2'b10;
  localparam logic [1:0] SELA_HOLD = 2'b11;

  localparam logic OP_ADD = 1'b1;
  localparam logic OP_SUB = 1'b0;

  typedef enum logic [1:0] {
    DUMP_IDLE = 2'b00,
    DUMP_LOAD = 2'b01,
    DUMP_SEND = 2'b10
  } dump_state_e;

endpackage

// File: rtl/bip_data_ram.sv
// Data RAM of the BIP core: one synchronous write port and two combinational
// read ports (A for the datapath, B for the dump engine). Contents are not reset.
module bip_data_ram #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 11
) (
  input  logic              clk_i,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic [ADDR_W-1:0] raddr_a_i,
  output logic [DATA_W-1:0] rdata_a_o,
  input  logic [ADDR_W-1:0] raddr_b_i,
  output logic [DATA_W-1:0] rdata_b_o
);

  logic [DATA_W-1:0] mem_q [2**ADDR_W];

  // Memory array write port
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_a_o = mem_q[raddr_a_i];
  assign rdata_b_o = mem_q[raddr_b_i];

endmodule

// File: rtl/bip_datapath.sv
// BIP execution datapath: accumulator, immediate sign extender, add/sub unit,
// data RAM and a handshaked engine that streams RAM words out after halt.
module bip_datapath
  import bip_pkg::*;
#(
  parameter int DATA_W   = 16,
  parameter int ADDR_W   = 11,
  parameter int DUMP_LEN = 16
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic [1:0]        SEL_A,
  input  logic              SEL_B,
  input  logic              WR_ACC,
  input  logic              OP,
  input  logic              WR_RAM,
  input  logic              RD_RAM,
  input  logic [ADDR_W-1:0] OPERAND,
  input  logic              HALT,
  input  logic              DUMP_REQ,
  input  logic              DBG_READY,
  output logic              DBG_VALID,
  output logic [DATA_W-1:0] DBG_DATA,
  output logic [ADDR_W-1:0] DBG_ADDR,
  output logic              DUMP_BUSY,
  output logic [DATA_W-1:0] ACC,
  output logic              ZERO,
  output logic              NEG
);

  localparam logic [ADDR_W-1:0] LAST_PTR = ADDR_W'(DUMP_LEN - 1);

  logic [DATA_W-1:0] acc_q, acc_d;
  logic              zero_q, neg_q;
  logic [DATA_W-1:0] imm_s, ram_rd_a_s, ram_rd_b_s, ram_a_s, b_s, alu_s;

  dump_state_e       state_q, state_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d;
  logic              dbg_valid_q, dbg_valid_d;
  logic [DATA_W-1:0] dbg_data_q, dbg_data_d;
  logic [ADDR_W-1:0] dbg_addr_q, dbg_addr_d;
  logic              busy_q, busy_d;

  bip_data_ram #(
    .DATA_W(DATA_W),
    .ADDR_W(ADDR_W)
  ) u_ram (
    .clk_i    (CLK),
    .we_i     (WR_RAM),
    .waddr_i  (OPERAND),
    .wdata_i  (acc_q),
    .raddr_a_i(OPERAND),
    .rdata_a_o(ram_rd_a_s),
    .raddr_b_i(ptr_q),
    .rdata_b_o(ram_rd_b_s)
  );

  assign imm_s   = {{(DATA_W-ADDR_W){OPERAND[ADDR_W-1]}}, OPERAND};
  assign ram_a_s = RD_RAM ? ram_rd_a_s : '0;
  assign b_s     = SEL_B ? imm_s : ram_a_s;
  assign alu_s   = (OP == OP_ADD) ? (acc_q + b_s) : (acc_q - b_s);

  // Accumulator source mux
  always_comb begin
    acc_d = acc_q;
    if (WR_ACC) begin
      case (SEL_A)
        SELA_RAM: acc_d = ram_a_s;
        SELA_IMM: acc_d = imm_s;
        SELA_ALU: acc_d = alu_s;
        default:  acc_d = acc_q;
      endcase
    end else begin
      acc_d = acc_q;
    end
  end

  // Accumulator and status flags; flags track the value being loaded
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      acc_q  <= '0;
      zero_q <= 1'b1;
      neg_q  <= 1'b0;
    end else begin
      acc_q  <= acc_d;
      zero_q <= (acc_d == '0);
      neg_q  <= acc_d[DATA_W-1];
    end
  end

  // Dump FSM next-state and output logic
  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    dbg_valid_d = dbg_valid_q;
    dbg_data_d  = dbg_data_q;
    dbg_addr_d  = dbg_addr_q;
    case (state_q)
      DUMP_IDLE: begin
        if (DUMP_REQ && HALT) begin
          ptr_d   = '0;
          state_d = DUMP_LOAD;
        end else begin
          state_d = DUMP_IDLE;
        end
      end
      DUMP_LOAD: begin
        dbg_data_d  = ram_rd_b_s;
        dbg_addr_d  = ptr_q;
        dbg_valid_d = 1'b1;
        state_d     = DUMP_SEND;
      end
      DUMP_SEND: begin
        if (DBG_READY) begin
          dbg_valid_d = 1'b0;
          if (ptr_q == LAST_PTR) begin
            state_d = DUMP_IDLE;
          end else begin
            ptr_d   = ptr_q + 1'b1;
            state_d = DUMP_LOAD;
          end
        end else begin
          state_d = DUMP_SEND;
        end
      end
      default: begin
        state_d     = DUMP_IDLE;
        dbg_valid_d = 1'b0;
      end
    endcase
    busy_d = (state_d != DUMP_IDLE);
  end

  // Dump FSM registers
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state_q     <= DUMP_IDLE;
      ptr_q       <= '0;
      dbg_valid_q <= 1'b0;
      dbg_data_q  <= '0;
      dbg_addr_q  <= '0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      dbg_valid_q <= dbg_valid_d;
      dbg_data_q  <= dbg_data_d;
      dbg_addr_q  <= dbg_addr_d;
      busy_q      <= busy_d;
    end
  end

  assign ACC       = acc_q;
  assign ZERO      = zero_q;
  assign NEG       = neg_q;
  assign DBG_VALID = dbg_valid_q;
  assign DBG_DATA  = dbg_data_q;
  assign DBG_ADDR  = dbg_addr_q;
  assign DUMP_BUSY = busy_q;

endmodule
